// File: rtl/key_debounce_pkg.sv
// Shared types and helpers for the key debouncer: channel FSM states and
// the ms-to-cycles conversion used to size debounce/auto-repeat counters.
package key_debounce_pkg;

    typedef enum logic [1:0] {
        ST_UP,
        ST_WAIT_DOWN,
        ST_DOWN,
        ST_WAIT_UP
    } db_state_e;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned ms);
        return clk_hz / 1000 * ms;
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key channel bundle: raw active-low key in, debounced level and event pulses out.
interface key_debounce_if #(
    parameter int W = 1
);
    logic [W-1:0] key_n;
    logic [W-1:0] level;
    logic [W-1:0] press;
    logic [W-1:0] rel;

    modport master (output key_n, input level, press, rel);
    modport slave  (input key_n, output level, press, rel);
endinterface

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop synchronizer, UP/WAIT_DOWN/DOWN/WAIT_UP FSM,
// saturating counters. Auto-repeat exists only with KEY_DEBOUNCE_AUTOREPEAT_EN.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 4
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    ,
    parameter int unsigned RPT_DELAY = 20,
    parameter int unsigned RPT_RATE  = 8
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    key_debounce_if.slave   bus
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          key_s;

    assign key_s   = sync_q[1];
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RMAX = max2(RPT_DELAY, RPT_RATE);
    localparam int RW = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(RPT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(RPT_RATE - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          rpt_fast_q, rpt_fast_d;
`endif

    always_comb begin
        sync_d  = {sync_q[0], bus.key_n[0]};
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        unique case (state_q)
            ST_UP: if (!key_s) begin
                state_d = ST_WAIT_DOWN;
                cnt_d   = '0;
            end
            ST_WAIT_DOWN: if (key_s) begin
                state_d = ST_UP;
                cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
                state_d = ST_DOWN;
                cnt_d   = '0;
                level_d = 1'b0;
                press_d = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
            end
            ST_DOWN: if (key_s) begin
                state_d = ST_WAIT_UP;
                cnt_d   = '0;
            end
            ST_WAIT_UP: if (!key_s) begin
                state_d = ST_DOWN;
                cnt_d   = '0;
            end else if (cnt_q == DB_LAST) begin
                state_d = ST_UP;
                cnt_d   = '0;
                level_d = 1'b1;
                rel_d   = 1'b1;
            end else begin
                cnt_d   = cnt_inc;
            end
            default: state_d = ST_UP;
        endcase

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        // Repeat timer only runs while settled in DOWN; any exit clears it.
        rpt_d      = '0;
        rpt_fast_d = 1'b0;
        if (state_q == ST_DOWN && !key_s) begin
            rpt_fast_d = rpt_fast_q;
            if (rpt_q == (rpt_fast_q ? RATE_LAST : DELAY_LAST)) begin
                press_d    = 1'b1;
                rpt_fast_d = 1'b1;
            end else begin
                rpt_d = (&rpt_q) ? rpt_q : rpt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            state_q    <= ST_UP;
            cnt_q      <= '0;
            level_q    <= 1'b1;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rpt_q      <= '0;
            rpt_fast_q <= 1'b0;
`endif
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            rpt_q      <= rpt_d;
            rpt_fast_q <= rpt_fast_d;
`endif
        end
    end

    assign bus.level = level_q;
    assign bus.press = press_q;
    assign bus.rel   = rel_q;

endmodule

// File: rtl/key_debounce.sv
// NUM_KEYS independent push-button debouncers feeding the key PIO.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat on key_press.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic                ref_clk_clk,
    input  logic                ref_reset_reset,
    input  logic [NUM_KEYS-1:0] key_n_in,
    output logic [NUM_KEYS-1:0] key_0_export,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int unsigned DB_CYCLES = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int unsigned RPT_DELAY = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int unsigned RPT_RATE  = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);
`endif

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_ch
        key_debounce_if #(.W(1)) ch_if ();

        assign ch_if.key_n      = key_n_in[i];
        assign key_0_export[i]  = ch_if.level;
        assign key_press[i]     = ch_if.press;
        assign key_release[i]   = ch_if.rel;

        key_debounce_ch #(
            .DB_CYCLES(DB_CYCLES)
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            ,
            .RPT_DELAY(RPT_DELAY),
            .RPT_RATE (RPT_RATE)
`endif
        ) u_ch (
            .clk  (ref_clk_clk),
            .rst_n(ref_reset_reset),
            .bus  (ch_if.slave)
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: table of key patterns plus hand sequences; expected
// pulse events are queued at drive time and matched as pulses appear.
module tb_key_debounce;

    localparam int NK  = 4;
    localparam int DB  = 4;
    localparam int LAT = 2 + DB;   // edges from first sampling edge to output

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    key_debounce_if #(.W(NK)) bus ();

    key_debounce #(
        .NUM_KEYS       (NK),
        .CLK_HZ         (4000),
        .DEBOUNCE_MS    (1),
        .REPEAT_DELAY_MS(5),
        .REPEAT_RATE_MS (2)
    ) dut (
        .ref_clk_clk    (clk),
        .ref_reset_reset(rst_n),
        .key_n_in       (bus.key_n),
        .key_0_export   (bus.level),
        .key_press      (bus.press),
        .key_release    (bus.rel)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } ev_t;

    typedef struct {
        logic [3:0] key_n;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[11];

    // Scoreboard: every pulse must match the oldest queued event exactly.
    always @(negedge clk) begin
        ev_t e;
        if (bus.press != 4'b0 || bus.rel != 4'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: cyc=%0d press=%b release=%b level=%b, required no pulse",
                         cyc, bus.press, bus.rel, bus.level);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.press != bus.press || e.rel != bus.rel || e.level != bus.level) begin
                    errors++;
                    $display("FAIL %s: got cyc=%0d press=%b release=%b level=%b, required cyc=%0d press=%b release=%b level=%b",
                             e.name, cyc, bus.press, bus.rel, bus.level, e.cyc, e.press, e.rel, e.level);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
            checks++;
            errors++;
            e = exp_q.pop_front();
            $display("FAIL %s: no pulse seen by cyc=%0d, required at cyc=%0d press=%b release=%b",
                     e.name, cyc, e.cyc, e.press, e.rel);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_ev(input string nm, input int at, input logic [3:0] p,
                             input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.name = nm; e.cyc = at; e.press = p; e.rel = r; e.level = l;
        exp_q.push_back(e);
    endtask

    task automatic check_val(input string nm, input logic [3:0] got, input logic [3:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, got, req);
        end
    endtask

    initial begin
        int c0;
        vecs[0]  = '{4'b1110, 4'b0001, 4'b0000, 4'b1110};
        vecs[1]  = '{4'b1111, 4'b0000, 4'b0001, 4'b1111};
        vecs[2]  = '{4'b0110, 4'b1001, 4'b0000, 4'b0110};
        vecs[3]  = '{4'b1111, 4'b0000, 4'b1001, 4'b1111};
        vecs[4]  = '{4'b1011, 4'b0100, 4'b0000, 4'b1011};
        vecs[5]  = '{4'b1111, 4'b0000, 4'b0100, 4'b1111};
        vecs[6]  = '{4'b0000, 4'b1111, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b1111, 4'b0000, 4'b1111, 4'b1111};
        vecs[8]  = '{4'b1110, 4'b0001, 4'b0000, 4'b1110};
        vecs[9]  = '{4'b1101, 4'b0010, 4'b0001, 4'b1101};
        vecs[10] = '{4'b1111, 4'b0000, 4'b0010, 4'b1111};

        bus.key_n = 4'b1111;
        rst_n     = 1'b0;
        tick(3);
        check_val("reset_level", bus.level, 4'b1111);
        check_val("reset_press", bus.press, 4'b0000);
        check_val("reset_release", bus.rel, 4'b0000);
        rst_n = 1'b1;
        tick(3);

        // Each drive lands on a negedge; the next posedge is the first sampler.
        foreach (vecs[i]) begin
            bus.key_n = vecs[i].key_n;
            expect_ev($sformatf("vec%0d", i), cyc + 1 + LAT, vecs[i].press, vecs[i].rel, vecs[i].level);
            tick(12);
            check_val($sformatf("vec%0d_level", i), bus.level, vecs[i].level);
        end

        // Bounce on key 1: 0,1,0,1 for two cycles each, then hold low.
        for (int k = 0; k < 4; k++) begin
            bus.key_n = (k % 2 == 0) ? 4'b1101 : 4'b1111;
            tick(2);
        end
        bus.key_n = 4'b1101;
        expect_ev("bounce_press", cyc + 1 + LAT, 4'b0010, 4'b0000, 4'b1101);
        tick(12);
        bus.key_n = 4'b1111;
        expect_ev("bounce_release", cyc + 1 + LAT, 4'b0000, 4'b0010, 4'b1111);
        tick(12);

        // Reset mid-hold: level snaps back to released, no release pulse.
        bus.key_n = 4'b0111;
        expect_ev("hold_press", cyc + 1 + LAT, 4'b1000, 4'b0000, 4'b0111);
        tick(12);
        rst_n = 1'b0;
        #1;
        check_val("midhold_reset_level", bus.level, 4'b1111);
        check_val("midhold_reset_press", bus.press, 4'b0000);
        bus.key_n = 4'b1111;
        tick(3);
        rst_n = 1'b1;
        tick(12);

        // Reset two cycles into WAIT_DOWN, button kept held through release.
        bus.key_n = 4'b1110;
        tick(5);
        rst_n = 1'b0;
        #1;
        check_val("middb_reset_level", bus.level, 4'b1111);
        check_val("middb_reset_press", bus.press, 4'b0000);
        tick(3);
        rst_n = 1'b1;
        expect_ev("post_reset_press", cyc + 1 + LAT, 4'b0001, 4'b0000, 4'b1110);
        tick(12);
        check_val("post_reset_level", bus.level, 4'b1110);
        bus.key_n = 4'b1111;
        expect_ev("post_reset_release", cyc + 1 + LAT, 4'b0000, 4'b0001, 4'b1111);
        tick(12);

        // Long hold on key 0 for 60 cycles.
        bus.key_n = 4'b1110;
        c0 = cyc + 1 + LAT;
        expect_ev("hold_first", c0, 4'b0001, 4'b0000, 4'b1110);
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
        for (int k = 0; k < 5; k++)
            expect_ev($sformatf("repeat%0d", k), c0 + 20 + 8 * k, 4'b0001, 4'b0000, 4'b1110);
`endif
        tick(60);
        bus.key_n = 4'b1111;
        expect_ev("hold_release", cyc + 1 + LAT, 4'b0000, 4'b0001, 4'b1111);
        tick(15);

        while (exp_q.size() != 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: pulse never seen, required at cyc=%0d press=%b release=%b",
                     e.name, e.cyc, e.press, e.rel);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
